// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the NTT processing-unit controller:
// FSM state encoding and the run-counter width helper.
package ntt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } ctrl_state_e;

    // Width needed to count 0..value-1, never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/ntt_rsp_buf.sv
// One-entry result register with valid/ready hand-off: capture, hold, release.
// With NTT_CTRL_PERF_EN defined it also keeps transform and stall counters.
module ntt_rsp_buf #(
    parameter int W = 272
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cap_en,
    input  logic [W-1:0] cap_data,
    input  logic         cap_inv,
    input  logic         rsp_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         rsp_inv
`ifdef NTT_CTRL_PERF_EN
    ,
    output logic [31:0]  perf_xforms,
    output logic [31:0]  perf_stall
`endif
);

    // Capture only ever lands on an empty or emptying entry, so it takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_inv   <= 1'b0;
        end else if (cap_en) begin
            rsp_valid <= 1'b1;
            rsp_data  <= cap_data;
            rsp_inv   <= cap_inv;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef NTT_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_xforms <= '0;
            perf_stall  <= '0;
        end else begin
            if (cap_en) begin
                perf_xforms <= perf_xforms + 32'd1;
            end
            if (rsp_valid && !rsp_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/ntt_pu_controller.sv
// Sequencer around the NTT/INTT processing unit: accepts a request, parks/releases
// the PU for its fixed run length, captures the result. Optional NTT_CTRL_PERF_EN counters.
module ntt_pu_controller
    import ntt_ctrl_pkg::*;
#(
    parameter int N      = 17,
    parameter int D      = 16,
    parameter int STAGES = $clog2(D),
    parameter int PU_LAT = STAGES + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_inv,
    input  logic [D*N-1:0] req_data,
    output logic           pu_rst,
    output logic           pu_inv,
    output logic [D*N-1:0] pu_a,
    input  logic [D*N-1:0] pu_an,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_inv,
    output logic [D*N-1:0] rsp_data,
    output logic           busy
`ifdef NTT_CTRL_PERF_EN
    ,
    output logic [31:0]    perf_xforms,
    output logic [31:0]    perf_stall
`endif
);

    localparam int               DW       = D * N;
    localparam int               CNT_W    = clog2(PU_LAT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PU_LAT - 1);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic [CNT_W-1:0] run_cnt;
    logic             accept;
    logic             capture;

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CLEAR;
            CLEAR:   state_d = RUN;
            RUN:     if (run_cnt == LAST_CNT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The PU is held in reset everywhere except RUN, so it is parked while idle.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        pu_rst    = 1'b1;
        capture   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = !rsp_valid || rsp_ready;
                busy      = 1'b0;
            end
            CLEAR: begin
                pu_rst = 1'b1;
            end
            RUN: begin
                pu_rst  = 1'b0;
                capture = (run_cnt == LAST_CNT);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt <= '0;
        end else if (state_q == RUN && run_cnt != LAST_CNT) begin
            run_cnt <= run_cnt + CNT_W'(1);
        end else begin
            run_cnt <= '0;
        end
    end

    // PU operands stay frozen from one accept to the next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pu_a   <= '0;
            pu_inv <= 1'b0;
        end else if (accept) begin
            pu_a   <= req_data;
            pu_inv <= req_inv;
        end
    end

`ifdef NTT_CTRL_PERF_EN
    ntt_rsp_buf #(
        .W(DW)
    ) u_rsp_buf (
        .clk         (clk),
        .rst         (rst),
        .cap_en      (capture),
        .cap_data    (pu_an),
        .cap_inv     (pu_inv),
        .rsp_ready   (rsp_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_inv     (rsp_inv),
        .perf_xforms (perf_xforms),
        .perf_stall  (perf_stall)
    );
`else
    ntt_rsp_buf #(
        .W(DW)
    ) u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (capture),
        .cap_data  (pu_an),
        .cap_inv   (pu_inv),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_inv   (rsp_inv)
    );
`endif

endmodule

// File: tb/tb_ntt_pu_controller.sv
// Bench for ntt_pu_controller with a behavioural DFT-based PU (q = 65537) and a
// transaction-level reference model; NTT_CTRL_PERF_EN adds counter checks.
`timescale 1ns/1ps
module tb_ntt_pu_controller;

    localparam int          N      = 17;
    localparam int          D      = 16;
    localparam int          STAGES = $clog2(D);
    localparam int          PU_LAT = STAGES + 1;
    localparam int          DW     = D * N;
    localparam logic [63:0] Q      = 64'd65537;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_inv = 1'b0;
    logic [DW-1:0] req_data = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready, pu_rst, pu_inv, rsp_valid, rsp_inv, busy;
    logic [DW-1:0] pu_a, pu_an, rsp_data;
`ifdef NTT_CTRL_PERF_EN
    logic [31:0]   perf_xforms, perf_stall;
`endif

    ntt_pu_controller #(.N(N), .D(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_inv(req_inv), .req_data(req_data),
        .pu_rst(pu_rst), .pu_inv(pu_inv), .pu_a(pu_a), .pu_an(pu_an),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inv(rsp_inv), .rsp_data(rsp_data),
        .busy(busy)
`ifdef NTT_CTRL_PERF_EN
        , .perf_xforms(perf_xforms), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mpow(input logic [63:0] base, input logic [63:0] e);
        logic [63:0] r, b, x;
        r = 64'd1;
        b = base % Q;
        x = e;
        while (x != 0) begin
            if (x[0]) r = (r * b) % Q;
            b = (b * b) % Q;
            x = x >> 1;
        end
        return r;
    endfunction

    // Natural-order length-D transform over Z_65537; inverse includes the 1/D scale.
    function automatic logic [DW-1:0] xform(input logic [DW-1:0] a, input logic inv);
        logic [DW-1:0] o;
        logic [63:0]   w, acc, ai, dinv;
        o    = '0;
        w    = mpow(64'd3, (Q - 64'd1) / 64'(D));
        if (inv) w = mpow(w, 64'(D - 1));
        dinv = mpow(64'(D), Q - 64'd2);
        for (int k = 0; k < D; k++) begin
            acc = 64'd0;
            for (int i = 0; i < D; i++) begin
                ai        = '0;
                ai[N-1:0] = a[i*N +: N];
                acc       = (acc + (ai % Q) * mpow(w, 64'((i * k) % D))) % Q;
            end
            if (inv) acc = (acc * dinv) % Q;
            o[k*N +: N] = acc[N-1:0];
        end
        return o;
    endfunction

    // PU model: result is only correct in the last cycle of a full run after reset release.
    int pu_cnt = 0;
    always @(posedge clk) pu_cnt <= pu_rst ? 0 : pu_cnt + 1;
    always_comb begin
        pu_an = xform(pu_a, pu_inv);
        if (pu_rst || pu_cnt != PU_LAT - 1) pu_an = ~pu_an;
    end

    int            tests = 0, failed = 0, iter = 0, acc_iter = 0, left = 0;
    int            perf_x = 0, perf_s = 0;
    logic          exp_valid = 1'b0, exp_inv = 1'b0, lat_inv = 1'b0;
    logic [DW-1:0] exp_data = '0, lat_a = '0;
    logic          s_acc = 1'b0, s_hs = 1'b0, s_rsp_valid = 1'b0, s_rsp_inv = 1'b0;
    logic [DW-1:0] s_rsp_data = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One cycle: inputs were set at this negedge; sample, check, advance the model.
    task automatic step();
        logic exp_ready;
        #1;
        if (!rst) begin
            left = 0; exp_valid = 1'b0; exp_data = '0; exp_inv = 1'b0;
            lat_a = '0; lat_inv = 1'b0; perf_x = 0; perf_s = 0;
        end
        exp_ready = (left == 0) && (!exp_valid || rsp_ready);
        chk("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid || !rst) begin
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_inv", rsp_inv, exp_inv);
        end
        chk("busy", busy, left > 0);
        chk("req_ready", req_ready, exp_ready);
        chk("pu_rst", pu_rst, !(left >= 1 && left <= PU_LAT));
        chk("pu_a", pu_a, lat_a);
        chk("pu_inv", pu_inv, lat_inv);
`ifdef NTT_CTRL_PERF_EN
        chk("perf_xforms", perf_xforms, perf_x);
        chk("perf_stall", perf_stall, perf_s);
`endif
        s_rsp_valid = rsp_valid;
        s_rsp_data  = rsp_data;
        s_rsp_inv   = rsp_inv;
        s_hs        = exp_valid && rsp_ready && rst;
        s_acc       = req_valid && exp_ready && rst;
        if (rst) begin
            if (exp_valid && !rsp_ready) perf_s++;
            if (s_hs) exp_valid = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    exp_valid = 1'b1;
                    exp_data  = xform(lat_a, lat_inv);
                    exp_inv   = lat_inv;
                    perf_x++;
                end
            end
            if (s_acc) begin
                lat_a    = req_data;
                lat_inv  = req_inv;
                left     = PU_LAT + 1;
                acc_iter = iter;
            end
        end
        iter++;
        @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic inv);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_data  = d;
        req_inv   = inv;
        do begin
            step();
            n++;
        end while (!s_acc && n < 50);
        chk("accept_seen", s_acc, 1'b1);
        req_valid = 1'b0;
        req_data  = ~d;
        req_inv   = ~inv;
    endtask

    task automatic wait_rsp(input logic [DW-1:0] exp_d, input logic exp_i, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_rsp_valid && n < 50);
        chk({tag, "_seen"}, s_rsp_valid, 1'b1);
        chk({tag, "_latency"}, (iter - 1) - acc_iter, PU_LAT + 2);
        chk({tag, "_data"}, s_rsp_data, exp_d);
        chk({tag, "_inv"}, s_rsp_inv, exp_i);
    endtask

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < D; i++) v[i*N +: N] = N'($urandom % 65537);
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] delta, ones, v, v2, held;
        logic          inv;
        logic [DW-1:0] q_data [4];
        logic          q_inv [4];
        int            n, sent, got;

        delta = '0;
        delta[0] = 1'b1;
        ones = '0;
        for (int i = 0; i < D; i++) ones[i*N] = 1'b1;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        step();
        step();
        rst = 1'b1;
        step();
        rsp_ready = 1'b1;

        send(delta, 1'b0);
        wait_rsp(ones, 1'b0, "fwd_delta");
        send(ones, 1'b1);
        wait_rsp(delta, 1'b1, "inv_ones");

        for (int t = 0; t < 4; t++) begin
            v   = rand_vec();
            inv = 1'($urandom % 2);
            send(v, inv);
            wait_rsp(xform(v, inv), inv, "rand");
        end
        v = rand_vec();
        send(xform(v, 1'b0), 1'b1);
        wait_rsp(v, 1'b1, "roundtrip");

        // Backpressure: result must hold and the next request must wait.
        rsp_ready = 1'b0;
        v = rand_vec();
        send(v, 1'b0);
        wait_rsp(xform(v, 1'b0), 1'b0, "bp");
        held      = s_rsp_data;
        v2        = rand_vec();
        req_valid = 1'b1;
        req_data  = v2;
        req_inv   = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            chk("bp_hold", s_rsp_data, held);
            chk("bp_no_accept", s_acc, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_both_handshakes", s_acc && s_hs, 1'b1);
        req_valid = 1'b0;
        wait_rsp(xform(v2, 1'b1), 1'b1, "bp_next");

        // Reset while the PU is in its third run cycle.
        send(delta, 1'b0);
        n = 0;
        while (left != PU_LAT - 2 && n < 20) begin
            step();
            n++;
        end
        chk("run_cnt2_reached", left, PU_LAT - 2);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        repeat (12) step();
        send(delta, 1'b0);
        wait_rsp(ones, 1'b0, "post_reset");

        // Back-to-back with the request held continuously.
        for (int k = 0; k < 4; k++) begin
            q_data[k] = rand_vec();
            q_inv[k]  = 1'($urandom % 2);
        end
        sent = 0;
        got  = 0;
        n    = 0;
        req_valid = 1'b1;
        req_data  = q_data[0];
        req_inv   = q_inv[0];
        while (got < 4 && n < 200) begin
            step();
            n++;
            if (s_rsp_valid) begin
                chk("b2b_data", s_rsp_data, xform(q_data[got], q_inv[got]));
                chk("b2b_inv", s_rsp_inv, q_inv[got]);
                got++;
            end
            if (s_acc) begin
                sent++;
                if (sent < 4) begin
                    req_data = q_data[sent];
                    req_inv  = q_inv[sent];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", got, 4);
`ifdef NTT_CTRL_PERF_EN
        chk("perf_xforms_total", perf_xforms, 32'd5);
        chk("perf_stall_total", perf_stall, 32'd0);
`endif
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
